// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes, exception codes and bus layouts for the memory stage.
// Packed structs list fields MSB first so they overlay the flat es/ms/ws buses directly.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 197;
    localparam int MS_TO_WS_BUS_WD = 192;
    localparam int MS_FWD_WD       = 57;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0b;
    localparam logic [5:0] ECODE_BRK = 6'h0c;
    localparam logic [5:0] ECODE_INE = 6'h0d;

    localparam int FWD_CSR_RE      = 56;
    localparam int FWD_CSR_NUM_HI  = 55;
    localparam int FWD_CSR_NUM_LO  = 42;
    localparam int FWD_CSR_WE      = 41;
    localparam int FWD_EX_ERTN     = 40;
    localparam int FWD_LOAD_PEND   = 39;
    localparam int FWD_RESULT_HI   = 38;
    localparam int FWD_RESULT_LO   = 7;
    localparam int FWD_DEST_HI     = 6;
    localparam int FWD_DEST_LO     = 2;
    localparam int FWD_RF_WE       = 1;
    localparam int FWD_MS_VALID    = 0;

    typedef struct packed {
        logic        rdcntid;
        logic [31:0] vaddr;
        logic        ertn;
        logic        esubcode;
        logic [5:0]  ecode;
        logic        ex;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        csr_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    // On the es side final_result carries the ALU result / memory address.
    typedef struct packed {
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic        mem_req;
        ms_to_ws_t   ws;
    } es_to_ms_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: byte/half select by address, then sign or zero extension.
// Purely combinational; unknown load types pass the word through untouched.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_type,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (ld_type)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_W:    load_data = rdata;
            LD_BU:   load_data = {24'd0, byte_sel};
            LD_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction from es, waits for its data-SRAM response, aligns load data.
// 1 cycle through when no memory request, otherwise released in the data_ok cycle; stalls on !ws_allowin.
// Responses that arrive while ws is stalled are buffered; responses of flushed instructions are counted and dropped.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_WD-1:0]       ms_forward
);

    es_to_ms_t   es_in;
    es_to_ms_t   es_cap;
    es_to_ms_t   ms_bus;
    ms_to_ws_t   ws_out;

    logic        ms_valid;
    logic        ms_ready_go;
    logic        data_ok_use;
    logic        capture;
    logic        to_ws;

    logic        rdata_buf_valid;
    logic [31:0] rdata_buf;
    logic [31:0] rdata_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    logic [1:0]  discard_cnt;
    logic [2:0]  discard_sum;
    logic        inc_ms;
    logic        inc_es;
    logic        dec;

    logic        unused_es_vaddr;

    assign es_in = es_to_ms_bus;

    // The incoming vaddr slot is ignored: ms reports the ALU result as the faulting address.
    always_comb begin
        es_cap          = es_in;
        es_cap.ws.vaddr = es_in.ws.final_result;
    end
    assign unused_es_vaddr = ^es_in.ws.vaddr;

    // A response is only ours once every stale response has been drained.
    assign data_ok_use    = data_sram_data_ok & (discard_cnt == 2'd0);
    assign ms_ready_go    = ~ms_bus.mem_req | data_ok_use | rdata_buf_valid;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign to_ws          = ms_to_ws_valid & ws_allowin;
    assign capture        = es_to_ms_valid & ms_allowin & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_bus <= '0;
        end else if (capture) begin
            ms_bus <= es_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdata_buf_valid <= 1'b0;
            rdata_buf       <= 32'd0;
        end else if (to_ws) begin
            rdata_buf_valid <= 1'b0;
        end else if (ms_valid && ms_bus.mem_req && data_ok_use && !rdata_buf_valid) begin
            rdata_buf_valid <= 1'b1;
            rdata_buf       <= data_sram_rdata;
        end
    end

    // Killed requests still get answered: the one held in ms and any es issues in the flush cycle.
    assign inc_ms      = flush & ms_valid & ms_bus.mem_req & ~data_ok_use & ~rdata_buf_valid;
    assign inc_es      = flush & es_to_ms_valid & es_in.mem_req;
    assign dec         = data_sram_data_ok & (discard_cnt != 2'd0);
    assign discard_sum = {1'b0, discard_cnt} + {2'b00, inc_ms} + {2'b00, inc_es} - {2'b00, dec};

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else begin
            discard_cnt <= (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
        end
    end

    assign rdata_sel = rdata_buf_valid ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .rdata     (rdata_sel),
        .addr      (ms_bus.ws.final_result[1:0]),
        .ld_type   (ms_bus.ld_type),
        .load_data (load_data)
    );

    assign final_result = ms_bus.res_from_mem ? load_data : ms_bus.ws.final_result;

    always_comb begin
        ws_out              = ms_bus.ws;
        ws_out.final_result = final_result;
    end
    assign ms_to_ws_bus = ws_out;

    always_comb begin
        ms_forward = '0;
        if (ms_valid) begin
            ms_forward[FWD_CSR_RE]                        = ms_bus.ws.csr_re;
            ms_forward[FWD_CSR_NUM_HI:FWD_CSR_NUM_LO]     = ms_bus.ws.csr_num;
            ms_forward[FWD_CSR_WE]                        = ms_bus.ws.csr_we;
            ms_forward[FWD_EX_ERTN]                       = ms_bus.ws.ex | ms_bus.ws.ertn;
            ms_forward[FWD_LOAD_PEND]                     = ms_bus.res_from_mem & ~ms_ready_go;
            ms_forward[FWD_RESULT_HI:FWD_RESULT_LO]       = final_result;
            ms_forward[FWD_DEST_HI:FWD_DEST_LO]           = ms_bus.ws.dest;
            ms_forward[FWD_RF_WE]                         = ms_bus.ws.gr_we & ~ms_bus.ws.ex;
            ms_forward[FWD_MS_VALID]                      = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of load-alignment vectors, directed corner sequences,
// then random traffic checked every cycle against a request-tagging reference model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [196:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [191:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [56:0]  ms_forward;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_forward        (ms_forward)
    );

    typedef struct {
        logic [2:0]  ld;
        logic        rfm;
        logic        mreq;
        logic        rdcntid;
        logic        ertn;
        logic        esub;
        logic [5:0]  ecode;
        logic        ex;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] wv;
        logic [31:0] wm;
        logic        csr_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } inst_t;

    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  a;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction held, whether its data already arrived,
    // and the in-order list of outstanding SRAM requests, each tagged killed or live.
    inst_t       es_inst;
    bit          mdl_on = 0;
    bit          m_valid = 0;
    inst_t       m_inst;
    bit          m_have = 0;
    logic [31:0] m_data;
    bit          oq[$];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_ext(input logic [2:0] t, input logic [31:0] w, input logic [1:0] a);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (a >= 2'd2) ? (w >> 16) : (w & 32'hFFFF);
        case (t)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic int killed_cnt();
        int n = 0;
        foreach (oq[j]) if (oq[j]) n++;
        return n;
    endfunction

    function automatic inst_t rnd_inst();
        inst_t i;
        int kind;
        kind      = $urandom_range(0, 2);
        i.ld      = 3'($urandom_range(0, 7));
        i.mreq    = (kind != 0);
        i.rfm     = (kind == 1);
        i.ex      = (kind == 0) && ($urandom_range(0, 7) == 0);
        i.ertn    = ($urandom_range(0, 15) == 0);
        i.rdcntid = 1'($urandom);
        i.esub    = 1'($urandom);
        i.ecode   = 6'($urandom);
        i.csr_re  = 1'($urandom);
        i.csr_num = 14'($urandom);
        i.wv      = $urandom;
        i.wm      = $urandom;
        i.csr_we  = 1'($urandom);
        i.gr_we   = 1'($urandom);
        i.dest    = 5'($urandom);
        i.alu     = $urandom;
        i.pc      = $urandom;
        return i;
    endfunction

    function automatic inst_t mk_load(input logic [2:0] ld, input logic [31:0] addr);
        inst_t i;
        i      = rnd_inst();
        i.ld   = ld;
        i.mreq = 1'b1;
        i.rfm  = 1'b1;
        i.ex   = 1'b0;
        i.alu  = addr;
        return i;
    endfunction

    task automatic present(input inst_t i);
        es_inst        = i;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {i.ld, i.rfm, i.mreq, i.rdcntid, 32'($urandom), i.ertn, i.esub, i.ecode,
                          i.ex, i.csr_re, i.csr_num, i.wv, i.wm, i.csr_we, i.gr_we, i.dest, i.alu, i.pc};
    endtask

    task automatic idle();
        reset             = 1'b0;
        flush             = 1'b0;
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
    endtask

    task automatic model_check();
        bit resp, ready;
        logic [31:0] fres;
        logic [56:0] efwd;
        resp  = data_sram_data_ok && oq.size() > 0 && !oq[0];
        ready = !m_inst.mreq || resp || m_have;
        fres  = m_inst.rfm ? ld_ext(m_inst.ld, m_have ? m_data : data_sram_rdata, m_inst.alu[1:0]) : m_inst.alu;
        chk("allowin", 192'(ms_allowin), 192'(!m_valid || (ready && ws_allowin)));
        chk("to_ws_valid", 192'(ms_to_ws_valid), 192'(m_valid && ready));
        efwd = '0;
        if (m_valid)
            efwd = {m_inst.csr_re, m_inst.csr_num, m_inst.csr_we, m_inst.ex | m_inst.ertn,
                    m_inst.rfm & !ready, fres, m_inst.dest, m_inst.gr_we & !m_inst.ex, 1'b1};
        chk("forward", 192'(ms_forward), 192'(efwd));
        if (m_valid)
            chk("ws_bus", ms_to_ws_bus,
                {m_inst.rdcntid, m_inst.alu, m_inst.ertn, m_inst.esub, m_inst.ecode, m_inst.ex,
                 m_inst.csr_re, m_inst.csr_num, m_inst.wv, m_inst.wm, m_inst.csr_we, m_inst.gr_we,
                 m_inst.dest, fres, m_inst.pc});
    endtask

    task automatic model_update();
        bit resp, ready, allow;
        resp  = data_sram_data_ok && oq.size() > 0 && !oq[0];
        ready = !m_inst.mreq || resp || m_have;
        allow = !m_valid || (ready && ws_allowin);
        if (reset) begin
            m_valid = 0;
            m_have  = 0;
            oq.delete();
            return;
        end
        if (data_sram_data_ok && oq.size() > 0) void'(oq.pop_front());
        if (flush) begin
            if (m_valid && m_inst.mreq && !m_have && !resp && oq.size() > 0) oq[oq.size() - 1] = 1'b1;
            if (es_to_ms_valid && es_inst.mreq) oq.push_back(1'b1);
            m_valid = 0;
            m_have  = 0;
        end else begin
            if (m_valid && resp && !ws_allowin) begin
                m_have = 1;
                m_data = data_sram_rdata;
            end
            if (allow) begin
                m_valid = es_to_ms_valid;
                m_have  = 0;
                if (es_to_ms_valid) begin
                    m_inst = es_inst;
                    if (es_inst.mreq) oq.push_back(1'b0);
                end
            end
        end
    endtask

    task automatic look();
        #2;
        if (mdl_on) model_check();
    endtask

    task automatic edge_t();
        @(posedge clk);
        if (mdl_on) model_update();
        @(negedge clk);
    endtask

    task automatic cyc();
        look();
        edge_t();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[12];
        inst_t a[4];
        inst_t t;

        vt[0]  = '{3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
        vt[1]  = '{3'b000, 2'd2, 32'h80FF_1234, 32'hFFFF_FFFF};
        vt[2]  = '{3'b000, 2'd0, 32'h80FF_1234, 32'h0000_0034};
        vt[3]  = '{3'b100, 2'd2, 32'h80FF_1234, 32'h0000_00FF};
        vt[4]  = '{3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080};
        vt[5]  = '{3'b001, 2'd2, 32'h80FF_1234, 32'hFFFF_80FF};
        vt[6]  = '{3'b001, 2'd0, 32'h80FF_1234, 32'h0000_1234};
        vt[7]  = '{3'b101, 2'd2, 32'h80FF_1234, 32'h0000_80FF};
        vt[8]  = '{3'b010, 2'd0, 32'h80FF_1234, 32'h80FF_1234};
        vt[9]  = '{3'b011, 2'd1, 32'h80FF_1234, 32'h80FF_1234};
        vt[10] = '{3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001};
        vt[11] = '{3'b000, 2'd1, 32'h0000_8000, 32'hFFFF_FF80};

        es_to_ms_bus = '0;
        es_inst      = rnd_inst();
        m_inst       = es_inst;
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle();
        mdl_on = 1;
        look();
        chk("reset_allowin", 192'(ms_allowin), 192'(1));
        chk("reset_to_ws_valid", 192'(ms_to_ws_valid), 192'(0));
        chk("reset_forward", 192'(ms_forward), 192'(0));
        edge_t();

        // ld.b, address ending in 3: valid exactly in the data_ok cycle
        idle(); present(mk_load(3'b000, 32'h0000_1003)); cyc();
        idle(); look();
        chk("t1_wait_valid", 192'(ms_to_ws_valid), 192'(0));
        chk("t1_load_pending", 192'(ms_forward[39]), 192'(1));
        edge_t();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234; look();
        chk("t1_valid", 192'(ms_to_ws_valid), 192'(1));
        chk("t1_final", 192'(ms_to_ws_bus[63:32]), 192'(32'hFFFF_FF80));
        edge_t();

        for (int k = 0; k < 12; k++) begin
            idle(); present(mk_load(vt[k].ld, 32'h0000_2000 | 32'(vt[k].a))); cyc();
            idle(); data_sram_data_ok = 1'b1; data_sram_rdata = vt[k].rd; look();
            chk("table_valid", 192'(ms_to_ws_valid), 192'(1));
            chk("table_final", 192'(ms_to_ws_bus[63:32]), 192'(vt[k].exp));
            edge_t();
        end

        // ld.hu with ws stalled: response held in the buffer
        idle(); present(mk_load(3'b101, 32'h0000_5002)); cyc();
        idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000; look();
        chk("t2_allowin_dok", 192'(ms_allowin), 192'(0));
        edge_t();
        for (int k = 0; k < 3; k++) begin
            idle(); ws_allowin = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; look();
            chk("t2_allowin_stall", 192'(ms_allowin), 192'(0));
            chk("t2_valid_stall", 192'(ms_to_ws_valid), 192'(1));
            edge_t();
        end
        idle(); look();
        chk("t2_final", 192'(ms_to_ws_bus[63:32]), 192'(32'h0000_8001));
        chk("t2_allowin_go", 192'(ms_allowin), 192'(1));
        edge_t();

        // flush while a load waits: its late response must be dropped
        idle(); present(mk_load(3'b010, 32'h0000_4000)); cyc();
        idle(); flush = 1'b1; cyc();
        idle(); present(mk_load(3'b010, 32'h0000_4004)); look();
        chk("t3_flushed", 192'(ms_forward[0]), 192'(0));
        edge_t();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; look();
        chk("t3_stale_drop", 192'(ms_to_ws_valid), 192'(0));
        edge_t();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222; look();
        chk("t3_valid", 192'(ms_to_ws_valid), 192'(1));
        chk("t3_final", 192'(ms_to_ws_bus[63:32]), 192'(32'h2222_2222));
        edge_t();

        // back-to-back ALU instructions
        for (int k = 0; k < 4; k++) begin
            a[k] = rnd_inst();
            a[k].mreq = 0; a[k].rfm = 0; a[k].ex = 0; a[k].ertn = 0; a[k].gr_we = 1;
            a[k].dest = 5'(k + 1);
            a[k].alu  = 32'h0000_0100 * (k + 1) + 32'h7;
        end
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) present(a[k]);
            look();
            if (k > 0) begin
                chk("t4_valid", 192'(ms_to_ws_valid), 192'(1));
                chk("t4_result", 192'(ms_forward[38:7]), 192'(a[k-1].alu));
                chk("t4_dest", 192'(ms_forward[6:2]), 192'(a[k-1].dest));
                chk("t4_rf_we", 192'(ms_forward[1]), 192'(1));
            end
            edge_t();
        end

        // exception instruction
        t = rnd_inst();
        t.ex = 1; t.mreq = 0; t.rfm = 0; t.ecode = 6'h09; t.alu = 32'h0000_1003; t.gr_we = 1;
        idle(); present(t); cyc();
        idle(); look();
        chk("t5_valid", 192'(ms_to_ws_valid), 192'(1));
        chk("t5_vaddr", 192'(ms_to_ws_bus[190:159]), 192'(32'h0000_1003));
        chk("t5_ecode", 192'(ms_to_ws_bus[156:151]), 192'(6'h09));
        chk("t5_rf_we", 192'(ms_forward[1]), 192'(0));
        chk("t5_ex_or_ertn", 192'(ms_forward[40]), 192'(1));
        edge_t();

        // build two stale responses plus a buffered one, then reset
        idle(); present(mk_load(3'b010, 32'h0000_3000)); cyc();
        idle(); present(mk_load(3'b010, 32'h0000_3004)); flush = 1'b1; cyc();
        idle(); present(mk_load(3'b010, 32'h0000_3008)); cyc();
        idle(); data_sram_data_ok = 1'b1; cyc();
        idle(); data_sram_data_ok = 1'b1; cyc();
        idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_7777; cyc();
        idle(); ws_allowin = 1'b0; reset = 1'b1; cyc();
        idle(); look();
        chk("t6_allowin", 192'(ms_allowin), 192'(1));
        chk("t6_to_ws_valid", 192'(ms_to_ws_valid), 192'(0));
        chk("t6_forward", 192'(ms_forward), 192'(0));
        edge_t();
        idle(); present(mk_load(3'b010, 32'h0000_300C)); cyc();
        idle(); look();
        chk("t6_buf_cleared", 192'(ms_to_ws_valid), 192'(0));
        edge_t();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4444_5555; look();
        chk("t6_cnt_cleared", 192'(ms_to_ws_valid), 192'(1));
        chk("t6_final", 192'(ms_to_ws_bus[63:32]), 192'(32'h4444_5555));
        edge_t();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 3) != 0) present(rnd_inst());
            ws_allowin        = ($urandom_range(0, 3) != 0);
            data_sram_data_ok = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
            flush             = ($urandom_range(0, 31) == 0) && (killed_cnt() <= 1);
            cyc();
        end
        for (int n = 0; n < 200 && (oq.size() > 0 || m_valid); n++) begin
            idle();
            data_sram_data_ok = (oq.size() > 0);
            cyc();
        end
        chk("drain_idle", 192'(oq.size() == 0 && !m_valid), 192'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
